// File: rtl/uio_bus_arbiter.sv
// Arbitrates two single-byte requesters onto the shared 8-bit uio pad bank,
// with turnaround gaps around each drive window. Define UIO_RR_EN for round-robin ties.
module uio_bus_arbiter #(
  parameter int unsigned HOLD = 2,
  parameter int unsigned TURN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       req0,
  input  logic       req1,
  input  logic       wr0,
  input  logic       wr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       busy
);

  localparam int unsigned CW = 4;
  localparam int unsigned DW = 8;
  localparam logic [CW-1:0] TURN_LAST = CW'(TURN - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);

  typedef enum logic [1:0] {S_IDLE, S_TURN, S_XFER, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_d, uio_out_d, uio_oe_d;
  logic          ack0_d, ack1_d, busy_d;
  logic          grant, winner;

  assign grant = ena && (req0 || req1);

`ifdef UIO_RR_EN
  logic last_q;

  // Tie goes to whoever was not granted last; a lone requester always wins.
  assign winner = (req0 && req1) ? ~last_q : ~req0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (state_q == S_IDLE && grant) begin
      last_q <= winner;
    end
  end
`else
  assign winner = ~req0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata   <= '0;
      uio_out <= '0;
      uio_oe  <= '0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata   <= rdata_d;
      uio_out <= uio_out_d;
      uio_oe  <= uio_oe_d;
      ack0    <= ack0_d;
      ack1    <= ack1_d;
      busy    <= busy_d;
    end
  end

  // Next state plus pad/handshake outputs derived from it, so every output is a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata;

    case (state_q)
      S_IDLE: begin
        if (grant) begin
          owner_d = winner;
          wr_d    = winner ? wr1 : wr0;
          wdata_d = winner ? wdata1 : wdata0;
          cnt_d   = '0;
          state_d = (TURN > 0) ? S_TURN : S_XFER;
        end
      end
      S_TURN: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = '0;
          state_d = S_XFER;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_XFER: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
          if (!wr_q) rdata_d = uio_in;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    uio_oe_d  = (state_d == S_XFER && wr_d) ? 8'hFF : 8'h00;
    uio_out_d = (state_d == S_XFER && wr_d) ? wdata_d : 8'h00;
    ack0_d    = (state_d == S_DONE) && !owner_d;
    ack1_d    = (state_d == S_DONE) && owner_d;
    busy_d    = (state_d != S_IDLE);
  end

endmodule

// File: doc/uio_bus_arbiter.md
# uio_bus_arbiter

Shares the 8-bit bidirectional `uio` pad bank of the `tt_um_erickespa` top level between two internal requesters. Each requester issues single-byte write (drive pads) or read (sample pads) transactions through a req/ack handshake. The block owns `uio_out`/`uio_oe`, inserts bus-turnaround cycles and arbitrates simultaneous requests. It sits directly between the core logic and the top-level `uio_*` ports.

## Interface
- `HOLD`, 2: cycles per transfer window (drive or sample); legal 1..15
- `TURN`, 1: turnaround cycles with `uio_oe`=0 before every transfer; legal 0..3

- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `ena`  in  1  design enable; low blocks new grants
- `req0`, `req1`  in  1  transaction request, held high until matching ack
- `wr0`, `wr1`  in  1  1 = write (drive), 0 = read (sample); valid while req high
- `wdata0`, `wdata1`  in  8  write byte; valid while req high
- `uio_in`  in  8  pad input path
- `uio_out`  out  8  pad output path
- `uio_oe`  out  8  pad enable, 8'hFF drive / 8'h00 input
- `ack0`, `ack1`  out  1  one-cycle completion pulse
- `rdata`  out  8  last byte read; valid in ack cycle of a read, holds until next read
- `busy`  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, TURN, XFER, DONE.
- IDLE: `uio_oe`=0. If `ena`=1 and any req is high, pick a winner. Latch owner, wr and wdata. Next state is TURN if TURN>0, else XFER.
- TURN: `uio_oe`=0 for exactly TURN cycles, then XFER.
- XFER: exactly HOLD cycles.
  - Write: `uio_oe`=8'hFF, `uio_out`=latched wdata.
  - Read: `uio_oe`=0. `rdata` captures `uio_in` at the clock edge ending the last XFER cycle.
  - Then DONE.
- DONE: one cycle. Owner's ack=1, `uio_oe`=0. Then IDLE.
- `uio_out`=8'h00 whenever not in XFER-write.
- Arbitration with simultaneous req0 and req1 is set by UIO_RR_EN (see Configuration). A single requester always wins.
- Owner data is latched at grant. Changes on wdata/wr or req drop after grant are ignored. The transaction completes and ack still pulses.
- `ena` low mid-transaction: the transaction completes. Only IDLE grants are blocked.
- Reset (async, any state): state=IDLE, `uio_oe`=0, `uio_out`=0, ack0=ack1=0, `rdata`=0, `busy`=0, last-owner flop=1.
- Requesters drop req after seeing ack. The DONE→IDLE cycle guarantees no stale regrant for registered requesters.

## Timing
- Grant decision is registered. IDLE cycle with req high is cycle 0.
- Transaction length = 1 (IDLE) + TURN + HOLD + 1 (DONE).
  - Default: cycle 0 IDLE, cycle 1 TURN, cycles 2–3 XFER, cycle 4 DONE/ack, cycle 5 IDLE.
- Back-to-back transactions: minimum TURN+HOLD+2 cycles apart. At least 1+TURN cycles of `uio_oe`=0 separate any two drive windows.
- `uio_oe` and `uio_out` are registered outputs with no combinational path from inputs.
- `rdata` is updated at the edge before the ack cycle. It is stable in the ack cycle and after it.
- `busy` rises at the edge after cycle 0 and falls at the edge ending DONE.

## Configuration
- `UIO_RR_EN` defined: round-robin. On a tie, grant the requester not granted last. The last-owner flop resets to 1, so the first tie goes to req0. The flop updates on every grant.
- `UIO_RR_EN` undefined: fixed priority, req0 always wins ties. The last-owner flop is not implemented.

## Test plan
- Reset mid-XFER write (`uio_oe`=FF). Assert `rst_n`=0 → same cycle: `uio_oe`=00, `uio_out`=00, `busy`=0. After release, first grant starts from IDLE.
- Default params. req0, wr0=1, wdata0=8'hA5 → cycle 1 `uio_oe`=00; cycles 2–3 `uio_oe`=FF with `uio_out`=A5; cycle 4 ack0=1 for one cycle only.
- Default params. req1, wr1=0, `uio_in`=8'h3C during cycle 3 (8'h00 in cycle 2) → cycle 4 ack1=1 and `rdata`=3C. `uio_oe` stays 00 throughout.
- req0 and req1 held simultaneously, both re-requesting after each ack:
  - With UIO_RR_EN: grants alternate 0,1,0,1.
  - Without UIO_RR_EN: req1 starves while req0 stays high.
- `ena`=0 with req0 high for 10 cycles → no grant, `busy`=0. Then `ena`=1 → grant on the next edge.
- `ena` dropped during XFER, or req0 dropped during TURN → transaction still completes, and ack0 pulses at cycle 4.
